pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_if.sv | 28 ++
 rtl/pipeline_hazard_ctrl.sv | 108 ++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bus between the pipeline datapath (master) and the hazard controller (slave).
// Carries ID/EX hazard inputs, the branch event, stage enables/flushes and perf counters.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs2;
  logic             idex_MemRead;
  logic [4:0]       idex_rd;
  logic             branch_taken;
  logic             PC_write;
  logic             IF_ID_write;
  logic             IF_ID_Flush;
  logic             ID_EX_Flush;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_events;

  modport master (
    output id_rs1, id_rs2, id_uses_rs2, idex_MemRead, idex_rd, branch_taken,
    input  PC_write, IF_ID_write, IF_ID_Flush, ID_EX_Flush, stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs2, idex_MemRead, idex_rd, branch_taken,
    output PC_write, IF_ID_write, IF_ID_Flush, ID_EX_Flush, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall and taken-branch flush controller for a 5-stage pipeline.
// Control outputs are combinational in state and inputs; perf counters saturate.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  pipeline_hazard_ctrl_if.slave bus
);
  localparam int unsigned FC_W = 3;
  localparam logic [FC_W-1:0] FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t          r_state, w_state_nxt;
  logic [FC_W-1:0] r_fcnt, w_fcnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles, r_flush_events;
  logic            w_hz;
  logic            w_stall;

  assign w_hz = bus.idex_MemRead && (bus.idex_rd != 5'd0) &&
                ((bus.idex_rd == bus.id_rs1) ||
                 (bus.id_uses_rs2 && (bus.idex_rd == bus.id_rs2)));

  // A stall is only ever taken in RUN with no branch competing for priority.
  assign w_stall = (r_state == RUN) && !bus.branch_taken && w_hz;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= RUN;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    case (r_state)
      RUN: begin
        if (bus.branch_taken && (FLUSH_CYCLES > 1)) begin
          w_state_nxt = FLUSH;
          w_fcnt_nxt  = FC_RELOAD;
        end
      end
      FLUSH: begin
        if (bus.branch_taken) begin
          if (FLUSH_CYCLES > 1) begin
            w_fcnt_nxt = FC_RELOAD;
          end else begin
            w_state_nxt = RUN;
            w_fcnt_nxt  = '0;
          end
        end else begin
          w_fcnt_nxt = r_fcnt - FC_W'(1);
          if (r_fcnt == FC_W'(1)) begin
            w_state_nxt = RUN;
          end
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_fcnt_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    bus.PC_write    = 1'b1;
    bus.IF_ID_write = 1'b1;
    bus.IF_ID_Flush = 1'b0;
    bus.ID_EX_Flush = 1'b0;
    if (reset) begin
      bus.PC_write    = 1'b0;
      bus.IF_ID_write = 1'b0;
      bus.IF_ID_Flush = 1'b1;
      bus.ID_EX_Flush = 1'b1;
    end else if ((r_state == FLUSH) || bus.branch_taken) begin
      bus.IF_ID_Flush = 1'b1;
      bus.ID_EX_Flush = 1'b1;
    end else if (w_hz) begin
      bus.PC_write    = 1'b0;
      bus.IF_ID_write = 1'b0;
      bus.ID_EX_Flush = 1'b1;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (bus.branch_taken && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
    end
  end

  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_events = r_flush_events;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: two controllers (FLUSH_CYCLES=2/CNT_W=32 and FLUSH_CYCLES=1/CNT_W=4)
// driven with identical directed steps and checked against a behavioural model.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.CNT_W(32)) if0 ();
  pipeline_hazard_ctrl_if #(.CNT_W(4))  if1 ();

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4))  dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  typedef struct {
    string            tag;
    int               dut;
    int               kind;
    logic [63:0]      val;
  } exp_t;

  exp_t q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  int              m_fc  [2] = '{2, 1};
  longint unsigned m_max [2] = '{64'hFFFF_FFFF, 64'd15};
  int              m_rem [2];
  longint unsigned m_stall[2];
  longint unsigned m_flush[2];

  function automatic logic [63:0] obs(input int dut, input int kind);
    if (dut == 0) begin
      case (kind)
        0:       obs = 64'({if0.PC_write, if0.IF_ID_write, if0.IF_ID_Flush, if0.ID_EX_Flush});
        1:       obs = 64'(if0.stall_cycles);
        default: obs = 64'(if0.flush_events);
      endcase
    end else begin
      case (kind)
        0:       obs = 64'({if1.PC_write, if1.IF_ID_write, if1.IF_ID_Flush, if1.ID_EX_Flush});
        1:       obs = 64'(if1.stall_cycles);
        default: obs = 64'(if1.flush_events);
      endcase
    end
  endfunction

  task automatic drain();
    exp_t e;
    logic [63:0] o;
    while (q.size() > 0) begin
      e = q.pop_front();
      o = obs(e.dut, e.kind);
      n_cmp++;
      assert (o === e.val) else begin
        n_fail++;
        $error("FAIL %s dut%0d kind%0d: observed %0h expected %0h", e.tag, e.dut, e.kind, o, e.val);
      end
    end
  endtask

  // One clock cycle: drive, check control outputs mid-cycle, advance model, check counters.
  task automatic step(input string tag, input logic rst, input logic br, input logic mr,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic u2);
    logic hz;
    logic [3:0] ctl;
    @(negedge clk);
    reset = rst;
    if0.branch_taken = br; if0.idex_MemRead = mr; if0.idex_rd = rd;
    if0.id_rs1 = rs1; if0.id_rs2 = rs2; if0.id_uses_rs2 = u2;
    if1.branch_taken = br; if1.idex_MemRead = mr; if1.idex_rd = rd;
    if1.id_rs1 = rs1; if1.id_rs2 = rs2; if1.id_uses_rs2 = u2;
    hz = mr && (rd != 5'd0) && ((rd == rs1) || (u2 && (rd == rs2)));
    for (int d = 0; d < 2; d++) begin
      if (rst)                     ctl = 4'b0011;
      else if (br || m_rem[d] > 0) ctl = 4'b1111;
      else if (hz)                 ctl = 4'b0001;
      else                         ctl = 4'b1100;
      q.push_back('{tag, d, 0, 64'(ctl)});
    end
    #1 drain();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_rem[d] = 0; m_stall[d] = 0; m_flush[d] = 0;
      end else begin
        if (!br && m_rem[d] == 0 && hz && m_stall[d] < m_max[d]) m_stall[d]++;
        if (br && m_flush[d] < m_max[d]) m_flush[d]++;
        if (br)               m_rem[d] = m_fc[d] - 1;
        else if (m_rem[d] > 0) m_rem[d]--;
      end
      q.push_back('{tag, d, 1, 64'(m_stall[d])});
      q.push_back('{tag, d, 2, 64'(m_flush[d])});
    end
    #1 drain();
  endtask

  initial begin
    reset = 1'b1;
    step("reset0", 1, 0, 0, 0, 0, 0, 0);
    step("reset1", 1, 1, 1, 5, 5, 0, 0);
    step("idle",   0, 0, 0, 0, 0, 0, 0);
    step("lu_rs1", 0, 0, 1, 5, 5, 0, 0);
    step("idle",   0, 0, 0, 5, 5, 0, 0);
    step("rd_x0",  0, 0, 1, 0, 0, 0, 0);
    step("rs2_unused", 0, 0, 1, 7, 1, 7, 0);
    step("lu_rs2", 0, 0, 1, 7, 1, 7, 1);
    step("nomem",  0, 0, 0, 7, 7, 7, 1);
    step("br",     0, 1, 0, 0, 0, 0, 0);
    step("br_fl2", 0, 0, 0, 0, 0, 0, 0);
    step("br_end", 0, 0, 0, 0, 0, 0, 0);
    step("br_hz",  0, 1, 1, 3, 3, 0, 0);
    step("fl_hz",  0, 0, 1, 3, 3, 0, 0);
    step("run_hz", 0, 0, 1, 3, 3, 0, 0);
    step("br_a",   0, 1, 0, 0, 0, 0, 0);
    step("br_b",   0, 1, 0, 0, 0, 0, 0);
    step("ext1",   0, 0, 0, 0, 0, 0, 0);
    step("ext_end",0, 0, 0, 0, 0, 0, 0);
    step("pre_rst",0, 1, 0, 0, 0, 0, 0);
    step("rst_fl", 1, 0, 1, 2, 2, 0, 0);
    step("post_rst", 0, 0, 0, 0, 0, 0, 0);
    step("post_rst2",0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("sat_hz", 0, 0, 1, 9, 9, 9, 1);
    step("sat_br", 0, 1, 1, 9, 9, 9, 1);
    step("final",  0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
